// File: rtl/lvc161_pkg.sv
`default_nettype none
// ============================================================================
// Package  : lvc161_pkg
// Purpose  : Shared state encoding and default sizing for the 74LVC161
//            modulo-N sequencer.
// Revision : 1.0  initial release
// ============================================================================
package lvc161_pkg;

   // Default cascade width in bits (two 4-bit counter stages).
   localparam int LVC_WIDTH_DEF = 8;

   // Smallest modulus the sequencer accepts by default.
   localparam int LVC_NMIN_DEF  = 2;

   // Bits per counter stage in the external cascade.
   localparam int LVC_STAGE_BITS = 4;

   // Sequencer state encoding.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } lvc_state_t;

endpackage : lvc161_pkg
`default_nettype wire

// File: rtl/lvc161_modn_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface : lvc161_modn_ctrl_if
// Purpose   : Control-side and cascade-side signals of the modulo-N
//             sequencer, bundled for connection between the control FSMs,
//             the sequencer and the external counter chain.
// Revision  : 1.0  initial release
// ============================================================================
interface lvc161_modn_ctrl_if #(
   parameter int WIDTH = 8
);

   // Control requests towards the sequencer
   logic             start;
   logic             periodic;
   logic [WIDTH-1:0] n_val;
   logic             pause;
   logic             stop;

   // Terminal count returned from the last cascade stage
   logic             tc_in;

   // Cascade drive from the sequencer
   logic             PE;
   logic             CEP;
   logic             CET;
   logic [WIDTH-1:0] D;

   // Status back to the control FSMs
   logic             busy;
   logic             tick;
   logic             done;
   logic             err;

   // Sequencer side
   modport slave (
      input  start, periodic, n_val, pause, stop, tc_in,
      output PE, CEP, CET, D, busy, tick, done, err
   );

   // Requester / cascade side
   modport master (
      output start, periodic, n_val, pause, stop, tc_in,
      input  PE, CEP, CET, D, busy, tick, done, err
   );

endinterface : lvc161_modn_ctrl_if
`default_nettype wire

// File: rtl/lvc161_modn_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lvc161_modn_ctrl
// Purpose  : Turns a free-running cascade of 74LVC161 counters into a
//            programmable modulo-N timer (one-shot or periodic). The
//            cascade is preset to 2^WIDTH - N so that its terminal count
//            fires after exactly N enabled clocks.
// Revision : 1.0  initial release
// ============================================================================
module lvc161_modn_ctrl
   import lvc161_pkg::*;
#(
   parameter int WIDTH = LVC_WIDTH_DEF,
   parameter int NMIN  = LVC_NMIN_DEF
) (
   input  wire logic          CP,
   input  wire logic          CR,
   lvc161_modn_ctrl_if.slave  bus
);

   localparam logic [WIDTH-1:0] c_NMIN = WIDTH'(NMIN);

   // Registered state and latched run parameters
   lvc_state_t        r_state;
   logic [WIDTH-1:0]  r_preset;
   logic              r_periodic;
   logic              r_tick;
   logic              r_done;
   logic              r_err;

   // Decoded next state and strobes
   lvc_state_t        w_next_state;
   logic [WIDTH-1:0]  w_preset;
   logic              w_wrap;
   logic              w_latch;
   logic              w_tick_set;
   logic              w_done_set;
   logic              w_err_set;
   logic              w_pe;
   logic              w_cep;
   logic              w_cet;
   logic [WIDTH-1:0]  w_d;

   // Two's complement of N: the cascade reaches all-ones after N-1 counts
   // and wraps on the Nth.
   assign w_preset = '0 - bus.n_val;

   // A terminal count only counts while the cascade is actually advancing.
   assign w_wrap   = bus.tc_in & ~bus.pause;

   // Next-state, cascade drive and pulse requests decoded from state
   always_comb begin
      w_next_state = r_state;
      w_latch      = 1'b0;
      w_tick_set   = 1'b0;
      w_done_set   = 1'b0;
      w_err_set    = 1'b0;
      w_pe         = 1'b1;
      w_cep        = 1'b0;
      w_cet        = 1'b0;
      w_d          = '0;

      case (r_state)
         ST_IDLE: begin
            // stop outranks a simultaneous start request
            if (!bus.stop && bus.start) begin
               if (bus.n_val < c_NMIN) begin
                  w_err_set = 1'b1;
               end else begin
                  w_latch      = 1'b1;
                  w_next_state = ST_LOAD;
               end
            end
         end

         ST_LOAD: begin
            // Counters stay disabled; the closing edge parallel-loads P.
            w_pe = 1'b0;
            w_d  = r_preset;
            if (bus.stop) begin
               w_next_state = ST_IDLE;
            end else begin
               w_next_state = ST_RUN;
            end
         end

         ST_RUN: begin
            w_cet = 1'b1;
            w_cep = ~bus.pause;
            w_d   = r_preset;
            if (bus.stop) begin
               w_next_state = ST_IDLE;
            end else if (w_wrap) begin
               w_tick_set = 1'b1;
               if (r_periodic) begin
                  // Reload on the very edge that would wrap, keeping the
                  // period at exactly N clocks.
                  w_pe = 1'b0;
               end else begin
                  w_next_state = ST_DONE;
               end
            end
         end

         ST_DONE: begin
            w_done_set   = 1'b1;
            w_next_state = ST_IDLE;
         end

         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // State register, latched run parameters and single-cycle status pulses
   always_ff @(posedge CP) begin
      if (CR) begin
         r_state    <= ST_IDLE;
         r_preset   <= '0;
         r_periodic <= 1'b0;
         r_tick     <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_tick  <= w_tick_set;
         r_done  <= w_done_set;
         r_err   <= w_err_set;
         if (w_latch) begin
            r_preset   <= w_preset;
            r_periodic <= bus.periodic;
         end
      end
   end

   assign bus.PE   = w_pe;
   assign bus.CEP  = w_cep;
   assign bus.CET  = w_cet;
   assign bus.D    = w_d;
   assign bus.busy = (r_state != ST_IDLE);
   assign bus.tick = r_tick;
   assign bus.done = r_done;
   assign bus.err  = r_err;

endmodule : lvc161_modn_ctrl
`default_nettype wire

// File: tb/tb_lvc161_modn_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lvc161_modn_ctrl (with lvc161_cascade load model)
// Purpose  : Drives the modulo-N sequencer into a behavioural 74LVC161
//            cascade and compares every cycle with a counting model.
// Revision : 1.0  initial release
// ============================================================================

// Chain of 4-bit synchronous counters, stage k TC feeding stage k+1 CET.
module lvc161_cascade #(
   parameter int WIDTH = 8
) (
   input  wire logic             CP,
   input  wire logic             PE,
   input  wire logic             CEP,
   input  wire logic             CET,
   input  wire logic [WIDTH-1:0] D,
   output logic      [WIDTH-1:0] Q,
   output logic                  TC
);
   logic [WIDTH/4:0] w_cet_chain;
   assign w_cet_chain[0] = CET;

   for (genvar k = 0; k < WIDTH/4; k++) begin : g_stage
      logic [3:0] r_q;
      // One 74LVC161: load beats count, count needs both enables
      always_ff @(posedge CP) begin
         if (!PE)                          r_q <= D[4*k +: 4];
         else if (CEP && w_cet_chain[k])   r_q <= r_q + 4'd1;
      end
      assign w_cet_chain[k+1] = w_cet_chain[k] & (r_q == 4'hF);
      assign Q[4*k +: 4]      = r_q;
   end

   assign TC = w_cet_chain[WIDTH/4];
endmodule : lvc161_cascade

module tb_lvc161_modn_ctrl;
   localparam int W    = 8;
   localparam int NMIN = 2;
   localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_DONE = 3;

   logic         clk = 1'b0;
   logic         cr  = 1'b1;
   logic [W-1:0] q;

   int nchk = 0;
   int nerr = 0;
   int cnt  = 0;
   int ticks[$];
   int dones[$];

   // Behavioural model: remaining enabled clocks until the next terminal edge
   int mode = M_IDLE;
   int rem  = 0;
   int mN   = 0;
   int mP   = 0;
   bit mper = 0;
   bit m_tick = 0, m_done = 0, m_err = 0;

   lvc161_modn_ctrl_if #(.WIDTH(W)) bus ();

   lvc161_modn_ctrl #(.WIDTH(W), .NMIN(NMIN)) dut (
      .CP  (clk),
      .CR  (cr),
      .bus (bus)
   );

   lvc161_cascade #(.WIDTH(W)) u_casc (
      .CP  (clk),
      .PE  (bus.PE),
      .CEP (bus.CEP),
      .CET (bus.CET),
      .D   (bus.D),
      .Q   (q),
      .TC  (bus.tc_in)
   );

   always #50 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      nchk++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int tk(input int i);
      if (i < ticks.size()) return ticks[i];
      return -100000;
   endfunction

   function automatic int dn(input int i);
      if (i < dones.size()) return dones[i];
      return -100000;
   endfunction

   // Per-cycle comparison of every meaningful DUT output against the model
   task automatic check_all();
      int e_pe, e_cep, e_cet, e_d;
      e_pe = 1; e_cep = 0; e_cet = 0; e_d = 0;
      if (mode == M_LOAD) begin
         e_pe = 0; e_d = mP;
      end else if (mode == M_RUN) begin
         e_cet = 1;
         e_cep = bus.pause ? 0 : 1;
         e_d   = mP;
         if (mper && rem == 1 && !bus.pause && !bus.stop) e_pe = 0;
         chk("Q", int'(q), (256 - rem) % 256);
      end
      chk("PE",   int'(bus.PE),   e_pe);
      chk("CEP",  int'(bus.CEP),  e_cep);
      chk("CET",  int'(bus.CET),  e_cet);
      chk("D",    int'(bus.D),    e_d);
      chk("busy", int'(bus.busy), (mode != M_IDLE) ? 1 : 0);
      chk("tick", int'(bus.tick), int'(m_tick));
      chk("done", int'(bus.done), int'(m_done));
      chk("err",  int'(bus.err),  int'(m_err));
      if (bus.tick) ticks.push_back(cnt);
      if (bus.done) dones.push_back(cnt);
   endtask

   // Advance the model across one clock edge using the inputs held there
   task automatic model_step();
      int n;
      n = int'(bus.n_val);
      m_tick = 0; m_done = 0; m_err = 0;
      if (cr) begin
         mode = M_IDLE;
      end else begin
         case (mode)
            M_IDLE: if (!bus.stop && bus.start) begin
               if (n < NMIN) m_err = 1;
               else begin
                  mN = n; mP = (256 - n) % 256; mper = bus.periodic; mode = M_LOAD;
               end
            end
            M_LOAD: begin
               if (bus.stop) mode = M_IDLE;
               else begin mode = M_RUN; rem = mN; end
            end
            M_RUN: begin
               if (bus.stop) mode = M_IDLE;
               else if (!bus.pause) begin
                  rem--;
                  if (rem == 0) begin
                     m_tick = 1;
                     if (mper) rem = mN;
                     else mode = M_DONE;
                  end
               end
            end
            default: begin m_done = 1; mode = M_IDLE; end
         endcase
      end
   endtask

   task automatic cyc();
      @(negedge clk);
      check_all();
      @(posedge clk);
      model_step();
      cnt++;
      #1;
   endtask

   initial begin
      int e0;
      int qf;
      bus.start = 0; bus.periodic = 0; bus.n_val = '0; bus.pause = 0; bus.stop = 0;
      cr = 1;
      @(posedge clk);
      #1;

      // Reset
      cyc();
      chk("rst_PE",   int'(bus.PE),   1);
      chk("rst_CEP",  int'(bus.CEP),  0);
      chk("rst_CET",  int'(bus.CET),  0);
      chk("rst_D",    int'(bus.D),    0);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_pulses", int'({bus.tick, bus.done, bus.err}), 0);
      cr = 0;

      // Periodic N=10
      bus.start = 1; bus.periodic = 1; bus.n_val = 8'd10;
      cyc(); e0 = cnt; bus.start = 0;
      chk("p10_load_D",  int'(bus.D),  'hF6);
      chk("p10_load_PE", int'(bus.PE), 0);
      ticks.delete();
      repeat (25) cyc();
      chk("p10_first_tick", tk(0) - e0, 11);
      chk("p10_period",     tk(1) - tk(0), 10);
      chk("p10_busy",       int'(bus.busy), 1);
      bus.stop = 1; cyc(); bus.stop = 0;
      chk("stop_busy", int'(bus.busy), 0);

      // One-shot N=3
      bus.start = 1; bus.periodic = 0; bus.n_val = 8'd3;
      cyc(); e0 = cnt; bus.start = 0;
      chk("os3_load_D", int'(bus.D), 'hFD);
      ticks.delete(); dones.delete();
      repeat (8) cyc();
      chk("os3_ntick",    ticks.size(), 1);
      chk("os3_tick_at",  tk(0) - e0, 4);
      chk("os3_done_at",  dn(0) - tk(0), 1);
      chk("os3_busy",     int'(bus.busy), 0);
      chk("os3_CEP",      int'(bus.CEP), 0);

      // Pause: periodic N=5, frozen for 4 cycles
      bus.start = 1; bus.periodic = 1; bus.n_val = 8'd5;
      cyc(); bus.start = 0;
      ticks.delete();
      repeat (8) cyc();
      qf = int'(q);
      bus.pause = 1; repeat (4) cyc(); bus.pause = 0;
      chk("pause_frozen", int'(q), qf);
      chk("pause_notick", ticks.size(), 1);
      repeat (8) cyc();
      chk("pause_interval", tk(1) - tk(0), 9);
      bus.stop = 1; cyc(); bus.stop = 0;

      // Bad moduli
      bus.start = 1; bus.n_val = 8'd1;
      cyc(); bus.start = 0;
      chk("bad1_err",  int'(bus.err),  1);
      chk("bad1_busy", int'(bus.busy), 0);
      cyc();
      chk("bad1_err_pulse", int'(bus.err), 0);
      bus.start = 1; bus.n_val = 8'd0;
      cyc(); bus.start = 0;
      chk("bad0_err",  int'(bus.err),  1);
      chk("bad0_busy", int'(bus.busy), 0);
      cyc();

      // Abort by stop, then by reset, then restart with N=4
      bus.start = 1; bus.periodic = 1; bus.n_val = 8'd10;
      cyc(); bus.start = 0;
      repeat (4) cyc();
      bus.stop = 1; cyc(); bus.stop = 0;
      chk("abort_stop_busy", int'(bus.busy), 0);
      bus.start = 1;
      cyc(); bus.start = 0;
      repeat (5) cyc();
      cr = 1; cyc(); cr = 0;
      chk("abort_cr_busy", int'(bus.busy), 0);
      chk("abort_cr_PE",   int'(bus.PE),   1);
      bus.start = 1; bus.n_val = 8'd4;
      cyc(); e0 = cnt; bus.start = 0;
      ticks.delete();
      repeat (14) cyc();
      chk("n4_first",  tk(0) - e0, 5);
      chk("n4_period", tk(1) - tk(0), 4);
      bus.stop = 1; cyc(); bus.stop = 0;

      // Randomized traffic against the model
      repeat (3000) begin
         bus.start    = ($urandom_range(0, 7) == 0);
         bus.periodic = $urandom_range(0, 1) != 0;
         bus.n_val    = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255))
                                                    : 8'($urandom_range(0, 40));
         bus.pause    = ($urandom_range(0, 5) == 0);
         bus.stop     = ($urandom_range(0, 59) == 0);
         cr           = ($urandom_range(0, 199) == 0);
         cyc();
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule : tb_lvc161_modn_ctrl
`default_nettype wire
